// File: rtl/mul_exec_unit.sv
// Iterative radix-2 shift-add multiplier for the execute stage.
// Produces a single-cycle register-bank write-back request per accepted operation.
module mul_exec_unit #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_signed,
    input  logic              op_hi,
    input  logic [ADDR_W-1:0] dest,
    input  logic [WIDTH-1:0]  opA,
    input  logic [WIDTH-1:0]  opB,
    output logic              busy,
    output logic              wb_write,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q;
    logic [CntW-1:0]     count_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]    mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic                neg_q;
    logic                hi_q;
    logic [ADDR_W-1:0]   dest_q;

    logic [WIDTH-1:0]    abs_a;
    logic [WIDTH-1:0]    abs_b;
    logic [WIDTH:0]      sum;
    logic [2*WIDTH-1:0]  prod;

    // Magnitudes; the most-negative value maps onto itself and is read as unsigned 2^(W-1).
    always_comb begin
        abs_a = (op_signed && opA[WIDTH-1]) ? -opA : opA;
        abs_b = (op_signed && opB[WIDTH-1]) ? -opB : opB;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod  = neg_q ? -acc_q : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= 1'b0;
            dest_q   <= '0;
            busy     <= 1'b0;
            wb_write <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_write <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= abs_a;
                        mplier_q <= abs_b;
                        neg_q    <= op_signed & (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        hi_q     <= op_hi;
                        dest_q   <= dest;
                        acc_q    <= '0;
                        count_q  <= '0;
                        busy     <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    // Carry out of the upper-half add lands in the MSB after the shift.
                    acc_q    <= {sum, acc_q[WIDTH-1:1]};
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CntW'(1);
                    if (count_q == CntW'(WIDTH - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    wb_data  <= hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
                    wb_addr  <= dest_q;
                    wb_write <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_exec_unit.sv
// Directed testbench for mul_exec_unit: latency, signed/unsigned lo/hi results,
// ignored starts while busy, async abort and back-to-back operation into a bank model.
module tb_mul_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_signed;
    logic        op_hi;
    logic [4:0]  dest;
    logic [63:0] opA;
    logic [63:0] opB;
    logic        busy;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;

    int checks;
    int failures;
    int strobes;
    int cyc;

    logic [63:0] bank [32];

    mul_exec_unit #(
        .WIDTH  (64),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_signed (op_signed),
        .op_hi     (op_hi),
        .dest      (dest),
        .opA       (opA),
        .opB       (opB),
        .busy      (busy),
        .wb_write  (wb_write),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wb_write) begin
            strobes <= strobes + 1;
            bank[wb_addr] <= wb_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally pulsing start mid-run, and check the write-back.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] d, input logic sgn, input logic hi,
                          input logic inject, input logic [63:0] exp);
        int n0;
        int lat;
        int busy_cyc;
        logic got;
        @(negedge clk);
        opA = a; opB = b; dest = d; op_signed = sgn; op_hi = hi; start = 1'b1;
        @(posedge clk);
        n0 = strobes;
        lat = 0;
        busy_cyc = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (wb_write) got = 1'b1;
            else if (busy) busy_cyc++;
            // Scramble inputs after acceptance; they must not matter.
            opA = ~a; opB = b ^ 64'h5A5A; dest = ~d; op_signed = ~sgn; op_hi = ~hi;
            start = inject && (lat == 10 || lat == 30);
        end
        start = 1'b0;
        check({tag, "_strobe"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'd66);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd65);
        check({tag, "_busy_at_strobe"}, 64'(busy), 64'd0);
        check({tag, "_addr"}, 64'(wb_addr), 64'(d));
        check({tag, "_data"}, wb_data, exp);
        @(negedge clk);
        check({tag, "_strobe_once"}, 64'(wb_write), 64'd0);
        check({tag, "_strobe_count"}, 64'(strobes - n0), 64'd1);
        if (inject) begin
            repeat (80) @(negedge clk);
            check({tag, "_no_extra_strobe"}, 64'(strobes - n0), 64'd1);
        end
    endtask

    logic [63:0] t6_a   [4] = '{64'd6, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'h8000_0000_0000_0000};
    logic [63:0] t6_b   [4] = '{64'd7, 64'h1_0000_0000, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [4:0]  t6_d   [4] = '{5'd0, 5'd9, 5'd17, 5'd31};
    logic        t6_s   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        t6_h   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] t6_exp [4] = '{64'd42, 64'd1, 64'hFFFF_FFFF_FFFF_FFFB,
                                64'h8000_0000_0000_0000};

    initial begin
        int n0;
        int w;
        int last;
        logic got;
        checks = 0; failures = 0; strobes = 0; cyc = 0;
        rst_n = 1'b0; start = 1'b0; op_signed = 1'b0; op_hi = 1'b0;
        dest = '0; opA = '0; opB = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_wb_write", 64'(wb_write), 64'd0);
        check("reset_wb_addr", 64'(wb_addr), 64'd0);
        check("reset_wb_data", wb_data, 64'd0);
        rst_n = 1'b1;

        run_op("t1_u_lo", 64'd3, 64'd5, 5'd7, 1'b0, 1'b0, 1'b0, 64'd15);
        run_op("t2_u_lo", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1'b0, 1'b0,
               1'b0, 64'd1);
        run_op("t2_u_hi", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 1'b0, 1'b1,
               1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("t3_s_lo", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd5, 1'b1, 1'b0, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFA);
        run_op("t3_s_hi", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd12, 1'b1, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF);
        run_op("t3_minneg_hi", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd20, 1'b1,
               1'b1, 1'b0, 64'd0);
        run_op("t4_ignore", 64'd1000, 64'd1000, 5'd21, 1'b0, 1'b0, 1'b1, 64'd1_000_000);

        // Abort mid-run: outputs clear immediately and the operation never writes back.
        @(negedge clk);
        opA = 64'd9; opB = 64'd9; dest = 5'd22; op_signed = 1'b0; op_hi = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n0 = strobes;
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_wb_write", 64'(wb_write), 64'd0);
        check("t5_rst_wb_addr", 64'(wb_addr), 64'd0);
        check("t5_rst_wb_data", wb_data, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("t5_no_strobe", 64'(strobes - n0), 64'd0);
        run_op("t5_after", 64'd12, 64'd11, 5'd23, 1'b0, 1'b0, 1'b0, 64'd132);

        // start held high: each strobe cycle presents the next operation's operands.
        @(negedge clk);
        opA = t6_a[0]; opB = t6_b[0]; dest = t6_d[0];
        op_signed = t6_s[0]; op_hi = t6_h[0]; start = 1'b1;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            w = 0;
            while (!got && w < 200) begin
                @(negedge clk);
                w++;
                if (wb_write) got = 1'b1;
            end
            check("t6_strobe", 64'(got), 64'd1);
            check("t6_data", wb_data, t6_exp[k]);
            if (k > 0) check("t6_gap", 64'(cyc - last), 64'd66);
            last = cyc;
            if (k < 3) begin
                opA = t6_a[k+1]; opB = t6_b[k+1]; dest = t6_d[k+1];
                op_signed = t6_s[k+1]; op_hi = t6_h[k+1];
            end else begin
                start = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("t6_bank", bank[t6_d[k]], t6_exp[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
